// File: rtl/bm_pack_fifo_if.sv
// Word-in / lane-out bus of the packing buffer, plus its status outputs.
// No logic of its own; it only carries signals between driver and buffer.
// Write side has no backpressure beyond in_rdy; read side is req/vld.
interface bm_pack_fifo_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 8,
    parameter int AW    = 15
);
    logic [IN_W-1:0]  in_data;
    logic             in_vld;
    logic             in_rdy;
    logic             clr;
    logic             out_req;
    logic [OUT_W-1:0] out_q;
    logic             out_vld;
    logic [AW:0]      level;
    logic             empty;
    logic             full;
    logic [15:0]      ovf_cnt;

    modport master (
        output in_data, in_vld, clr, out_req,
        input  in_rdy, out_q, out_vld, level, empty, full, ovf_cnt
    );

    modport slave (
        input  in_data, in_vld, clr, out_req,
        output in_rdy, out_q, out_vld, level, empty, full, ovf_cnt
    );
endinterface

// File: rtl/bm_pack_fifo.sv
// Word-to-lane packing buffer: each accepted word is split into R lanes stored in a RAM.
// Latency: accept -> first lane poppable 2 cycles; pop -> out_vld 1 cycle.
// Backpressure: in_rdy drops when the RAM cannot take a whole word; offered words are then dropped and counted.
module bm_pack_fifo #(
    parameter int IN_W      = 32,
    parameter int OUT_W     = 8,
    parameter int AW        = 15,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic            clk_sys,
    input  logic            rst_n,
    bm_pack_fifo_if.slave   bus
);
    localparam int R     = IN_W / OUT_W;
    localparam int LCW   = (R > 1) ? $clog2(R) : 1;
    localparam int DEPTH = 1 << AW;
    localparam int LW    = AW + 2;  // room for DEPTH plus a sign-free margin

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [LCW-1:0]   lane_q, lane_d;
    logic [IN_W-1:0]  data_q, data_d;
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      level_q, level_d;
    logic [15:0]      ovf_q, ovf_d;
    logic             out_vld_q, out_vld_d;
    logic [OUT_W-1:0] out_dat_q, out_dat_d;
    logic [OUT_W-1:0] mem_q [DEPTH];

    logic             last_lane, lane_wr, accept, drop, pop, mem_we, in_rdy, empty;
    logic [LW-1:0]    pending, space;
    logic [LCW-1:0]   lane_sel;
    logic [OUT_W-1:0] lane_dat;

    // Status, handshake and next-state for the serializer, pointers, level and read port
    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        data_d    = data_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        level_d   = level_q;
        ovf_d     = ovf_q;
        out_vld_d = 1'b0;
        out_dat_d = out_dat_q;
        mem_we    = 1'b0;

        // All flow-control terms come from registered state only
        lane_wr   = (state_q == SHIFT);
        last_lane = lane_wr && (lane_q == LCW'(R - 1));
        pending   = lane_wr ? (LW'(R) - LW'(lane_q)) : '0;
        space     = LW'(DEPTH) - LW'(level_q) - pending;
        in_rdy    = ((state_q == IDLE) || last_lane) && (space >= LW'(R));
        empty     = (level_q == '0);

        accept    = bus.in_vld && in_rdy;
        drop      = bus.in_vld && !in_rdy;
        pop       = bus.out_req && !empty;

        lane_sel  = MSB_FIRST ? (LCW'(R - 1) - lane_q) : lane_q;
        lane_dat  = data_q[int'(lane_sel) * OUT_W +: OUT_W];

        if (lane_wr) begin
            mem_we = 1'b1;
            wptr_d = wptr_q + 1'b1;
            if (last_lane) begin
                state_d = IDLE;
            end else begin
                lane_d = lane_q + 1'b1;
            end
        end
        // Accept on the last lane overrides the return to IDLE: back-to-back words
        if (accept) begin
            data_d  = bus.in_data;
            state_d = SHIFT;
            lane_d  = '0;
        end
        if (drop && (ovf_q != 16'hFFFF)) begin
            ovf_d = ovf_q + 16'd1;
        end
        if (pop) begin
            rptr_d    = rptr_q + 1'b1;
            out_vld_d = 1'b1;
            out_dat_d = mem_q[rptr_q];
        end
        level_d = level_q + (AW+1)'(lane_wr) - (AW+1)'(pop);

        // Flush wins over everything this cycle but keeps the drop count
        if (bus.clr) begin
            state_d   = IDLE;
            lane_d    = '0;
            wptr_d    = '0;
            rptr_d    = '0;
            level_d   = '0;
            ovf_d     = ovf_q;
            out_vld_d = 1'b0;
            out_dat_d = '0;
            mem_we    = 1'b0;
        end
    end

    // Control and datapath registers, synchronous reset
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lane_q    <= '0;
            data_q    <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            level_q   <= '0;
            ovf_q     <= '0;
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            data_q    <= data_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
        end
    end

    // Lane storage; contents are never reset, only slots counted by level are read
    always_ff @(posedge clk_sys) begin
        if (rst_n && mem_we) begin
            mem_q[wptr_q] <= lane_dat;
        end
    end

    assign bus.in_rdy  = in_rdy;
    assign bus.empty   = empty;
    assign bus.full    = (LW'(level_q) + pending) > LW'(DEPTH - R);
    assign bus.level   = level_q;
    assign bus.ovf_cnt = ovf_q;
    assign bus.out_vld = out_vld_q;
    assign bus.out_q   = out_dat_q;
endmodule

// File: tb/tb_bm_pack_fifo.sv
// Bench for bm_pack_fifo: two DUTs (MSB-first and LSB-first, depth 16) share one stimulus.
// Expected lanes are queued at issue time and checked by per-DUT monitors on out_vld.
// Status outputs are checked directly against hand-computed values.
module tb_bm_pack_fifo;
    logic clk_sys = 1'b0;
    logic rst_n   = 1'b0;
    always #5 clk_sys = ~clk_sys;

    bm_pack_fifo_if #(.IN_W(32), .OUT_W(8), .AW(4)) if_a ();
    bm_pack_fifo_if #(.IN_W(32), .OUT_W(8), .AW(4)) if_b ();

    bm_pack_fifo #(.IN_W(32), .OUT_W(8), .AW(4), .MSB_FIRST(1'b1)) dut_a (
        .clk_sys(clk_sys), .rst_n(rst_n), .bus(if_a));
    bm_pack_fifo #(.IN_W(32), .OUT_W(8), .AW(4), .MSB_FIRST(1'b0)) dut_b (
        .clk_sys(clk_sys), .rst_n(rst_n), .bus(if_b));

    int nchk  = 0;
    int nfail = 0;
    logic [7:0] qa [$];
    logic [7:0] qb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic drv(input logic v, input logic [31:0] d);
        if_a.in_vld = v; if_b.in_vld = v;
        if_a.in_data = d; if_b.in_data = d;
    endtask

    task automatic req(input logic r);
        if_a.out_req = r; if_b.out_req = r;
    endtask

    task automatic set_clr(input logic c);
        if_a.clr = c; if_b.clr = c;
    endtask

    // Expected lane streams: MSB-first for dut_a, LSB-first for dut_b
    task automatic push_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            qa.push_back(w[31-8*k -: 8]);
            qb.push_back(w[8*k +: 8]);
        end
    endtask

    task automatic status(input string t, input int lvl, input logic emp,
                          input logic ful, input logic rdy, input int ovf);
        chk({t, "_a_level"}, 32'(if_a.level), lvl);
        chk({t, "_a_empty"}, 32'(if_a.empty), 32'(emp));
        chk({t, "_a_full"},  32'(if_a.full),  32'(ful));
        chk({t, "_a_in_rdy"}, 32'(if_a.in_rdy), 32'(rdy));
        chk({t, "_a_ovf"},   32'(if_a.ovf_cnt), ovf);
        chk({t, "_b_level"}, 32'(if_b.level), lvl);
        chk({t, "_b_empty"}, 32'(if_b.empty), 32'(emp));
        chk({t, "_b_full"},  32'(if_b.full),  32'(ful));
        chk({t, "_b_in_rdy"}, 32'(if_b.in_rdy), 32'(rdy));
        chk({t, "_b_ovf"},   32'(if_b.ovf_cnt), ovf);
    endtask

    // Monitor for the MSB-first DUT
    always @(negedge clk_sys) begin
        if (rst_n && if_a.out_vld) begin
            if (qa.size() == 0) begin
                nchk++; nfail++;
                $display("FAIL mon_a_unexpected actual=%h required=no_lane", if_a.out_q);
            end else begin
                chk("mon_a_lane", 32'(if_a.out_q), 32'(qa.pop_front()));
            end
        end
    end

    // Monitor for the LSB-first DUT
    always @(negedge clk_sys) begin
        if (rst_n && if_b.out_vld) begin
            if (qb.size() == 0) begin
                nchk++; nfail++;
                $display("FAIL mon_b_unexpected actual=%h required=no_lane", if_b.out_q);
            end else begin
                chk("mon_b_lane", 32'(if_b.out_q), 32'(qb.pop_front()));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        int acc, n, lat;
        logic found;

        drv(1'b0, 32'h0); req(1'b0); set_clr(1'b0);
        cyc(); cyc();
        rst_n = 1'b1;
        status("reset", 0, 1'b1, 1'b0, 1'b1, 0);
        chk("reset_a_out_vld", 32'(if_a.out_vld), 0);

        // Single word, then four pops
        drv(1'b1, 32'hA1B2C3D4); push_word(32'hA1B2C3D4);
        cyc();
        drv(1'b0, 32'h0);
        chk("t1_level_after_accept", 32'(if_a.level), 0);
        cyc();
        chk("t1_level_1", 32'(if_a.level), 1);
        chk("t1_empty_0", 32'(if_a.empty), 0);
        cyc(); cyc(); cyc();
        status("t1_loaded", 4, 1'b0, 1'b0, 1'b1, 0);
        req(1'b1);
        repeat (4) cyc();
        req(1'b0);
        status("t1_drained", 0, 1'b1, 1'b0, 1'b1, 0);
        cyc(); cyc();
        chk("t1_a_out_q_hold", 32'(if_a.out_q), 32'hD4);
        chk("t1_b_out_q_hold", 32'(if_b.out_q), 32'hA1);
        chk("t1_out_vld_idle", 32'(if_a.out_vld), 0);

        // Three words chained on the last-lane cycle: full rate
        drv(1'b1, 32'h11223344); push_word(32'h11223344);
        cyc(); drv(1'b0, 32'h0);
        cyc(); cyc(); cyc();
        chk("t3_rdy_on_last_lane", 32'(if_a.in_rdy), 1);
        drv(1'b1, 32'h55667788); push_word(32'h55667788);
        cyc(); drv(1'b0, 32'h0);
        cyc(); cyc(); cyc();
        drv(1'b1, 32'h99AABBCC); push_word(32'h99AABBCC);
        cyc(); drv(1'b0, 32'h0);
        repeat (4) cyc();
        status("t3_12_lanes", 12, 1'b0, 1'b0, 1'b1, 0);
        req(1'b1);
        repeat (12) cyc();
        req(1'b0);
        cyc();
        chk("t3_empty", 32'(if_a.empty), 1);

        // Fill to depth 16 with no pops; fifth word is dropped
        for (int i = 0; i < 5; i++) begin
            w = {8'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i), 8'(8'h40 + i)};
            if (i == 3) chk("t4_rdy_space_exact", 32'(if_a.in_rdy), 1);
            if (i == 4) status("t4_before_drop", 15, 1'b0, 1'b1, 1'b0, 0);
            drv(1'b1, w);
            if (i < 4) push_word(w);
            cyc();
            drv(1'b0, 32'h0);
            if (i < 4) begin cyc(); cyc(); cyc(); end
        end
        status("t4_full", 16, 1'b0, 1'b1, 1'b0, 1);
        set_clr(1'b1);
        cyc();
        set_clr(1'b0);
        qa.delete(); qb.delete();
        status("t4_after_clr", 0, 1'b1, 1'b0, 1'b1, 1);
        chk("t4_clr_out_vld", 32'(if_a.out_vld), 0);

        // Pop requests while empty are ignored; then measure pop latency
        req(1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t5_empty_req_vld", 32'(if_a.out_vld), 0);
        end
        drv(1'b1, 32'hCAFE0123); push_word(32'hCAFE0123);
        cyc();
        drv(1'b0, 32'h0);
        lat = 1; found = 1'b0;
        while (!found && lat < 10) begin
            if (if_a.out_vld) found = 1'b1;
            else begin cyc(); lat++; end
        end
        chk("t5_first_vld_cycle", lat, 3);
        repeat (6) cyc();
        req(1'b0);
        cyc();
        status("t5_drained", 0, 1'b1, 1'b0, 1'b1, 1);

        // Stream 40 words with random pops across many wraps
        acc = 0; n = 0;
        while (acc < 40 && n < 2000) begin
            req(1'($urandom_range(0, 1)));
            if (if_a.in_rdy) begin
                w = {8'(acc), 8'(acc + 64), 8'(acc + 128), 8'(~acc)};
                push_word(w);
                drv(1'b1, w);
                acc++;
            end else begin
                drv(1'b0, 32'h0);
            end
            cyc();
            n++;
        end
        drv(1'b0, 32'h0);
        chk("t6_words_accepted", acc, 40);
        req(1'b1);
        n = 0;
        while ((qa.size() > 0 || qb.size() > 0) && n < 300) begin
            cyc();
            n++;
        end
        req(1'b0);
        cyc();
        chk("t6_a_lanes_left", qa.size(), 0);
        chk("t6_b_lanes_left", qb.size(), 0);
        status("t6_drained", 0, 1'b1, 1'b0, 1'b1, 1);

        // Reset in the middle of a word discards it and clears the drop count
        drv(1'b1, 32'hDEADBEEF);
        cyc();
        drv(1'b0, 32'h0);
        cyc(); cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        qa.delete(); qb.delete();
        status("t6_reset", 0, 1'b1, 1'b0, 1'b1, 0);

        // Clean operation after that reset
        drv(1'b1, 32'h0F1E2D3C); push_word(32'h0F1E2D3C);
        cyc();
        drv(1'b0, 32'h0);
        req(1'b1);
        repeat (8) cyc();
        req(1'b0);
        cyc();
        chk("t6_post_reset_a_left", qa.size(), 0);
        chk("t6_post_reset_b_left", qb.size(), 0);
        chk("t6_post_reset_empty", 32'(if_a.empty), 1);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule
